// File: rtl/sm4_core_iter.sv
// Iterative SM4 encrypt/decrypt engine running ROUNDS_PER_CYCLE rounds per clock behind valid/ready handshakes.
// Optional macro SM4_BLOCK_CNT_EN adds a 32-bit count of delivered blocks on port blk_cnt.
module sm4_core_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode,
    input  logic [127:0] key,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out
`ifdef SM4_BLOCK_CNT_EN
    ,
    output logic [31:0]  blk_cnt
`endif
);

    localparam int ITER_CNT = 32 / ROUNDS_PER_CYCLE;
    localparam int CNT_W    = $clog2(ITER_CNT) + 1;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rounds
        $error("sm4_core_iter: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    function automatic logic [31:0] l_data(input logic [31:0] b);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ rol(b, 13) ^ rol(b, 23);
    endfunction

    // CK byte j of round i is (4*i+j)*7 mod 256, so no table is needed.
    function automatic logic [31:0] ck(input int i);
        logic [31:0] c;
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c = {c[23:0], 8'((4 * i + j) * 7)};
        end
        return c;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [127:0]       key_reg;
    logic               mode_reg;
    logic [127:0]       x_reg, x_next;
    logic [127:0]       data_out_reg;
    logic [31:0]        kx [36];
    logic [31:0]        rk [32];
    logic [4:0]         rk_idx [ROUNDS_PER_CYCLE];
    logic [31:0]        rk_cur [ROUNDS_PER_CYCLE];

    always_comb begin
        kx[0] = key_reg[127:96] ^ FK[127:96];
        kx[1] = key_reg[95:64]  ^ FK[95:64];
        kx[2] = key_reg[63:32]  ^ FK[63:32];
        kx[3] = key_reg[31:0]   ^ FK[31:0];
        for (int i = 0; i < 32; i++) begin
            kx[i + 4] = kx[i] ^ l_key(tau(kx[i + 1] ^ kx[i + 2] ^ kx[i + 3] ^ ck(i)));
            rk[i]     = kx[i + 4];
        end
    end

    // Decryption walks the same schedule backwards.
    for (genvar gi = 0; gi < ROUNDS_PER_CYCLE; gi++) begin : g_rk
        assign rk_idx[gi] = 5'(int'(cnt_reg) * ROUNDS_PER_CYCLE + gi);
        assign rk_cur[gi] = mode_reg ? rk[5'd31 - rk_idx[gi]] : rk[rk_idx[gi]];
    end

    // Window holds X(i)..X(i+3) with X(i) in the top word.
    always_comb begin
        x_next = x_reg;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            x_next = {x_next[95:0],
                      x_next[127:96] ^ l_data(tau(x_next[95:64] ^ x_next[63:32] ^ x_next[31:0] ^ rk_cur[r]))};
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt_reg == CNT_W'(ITER_CNT - 1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            key_reg      <= '0;
            mode_reg     <= 1'b0;
            x_reg        <= '0;
            data_out_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (in_valid) begin
                    key_reg  <= key;
                    mode_reg <= mode;
                    x_reg    <= data_in;
                    cnt_reg  <= '0;
                end
                RUN: begin
                    x_reg   <= x_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (state_next == DONE)
                        data_out_reg <= {x_next[31:0], x_next[63:32], x_next[95:64], x_next[127:96]};
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign data_out  = data_out_reg;

`ifdef SM4_BLOCK_CNT_EN
    logic [31:0] blk_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)
            blk_cnt_reg <= '0;
        else if (out_valid && out_ready)
            blk_cnt_reg <= blk_cnt_reg + 32'd1;
    end

    assign blk_cnt = blk_cnt_reg;
`endif

endmodule

// File: tb/tb_sm4_core_iter.sv
// Directed bench for sm4_core_iter: one R=1 and one R=8 instance, results checked through an expected-value queue.
module tb_sm4_core_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         mode      [2];
    logic [127:0] key       [2];
    logic [127:0] data_in   [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] data_out  [2];
`ifdef SM4_BLOCK_CNT_EN
    logic [31:0]  blk_cnt   [2];
`endif

    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q [$];

    localparam logic [127:0] KEY_STD = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT_STD  = 128'h681edf34d206965e86b3e94f536e4246;

    sm4_core_iter #(.ROUNDS_PER_CYCLE(1)) u_r1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode[0]),
        .key(key[0]), .data_in(data_in[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .data_out(data_out[0])
`ifdef SM4_BLOCK_CNT_EN
        , .blk_cnt(blk_cnt[0])
`endif
    );

    sm4_core_iter #(.ROUNDS_PER_CYCLE(8)) u_r8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode[1]),
        .key(key[1]), .data_in(data_in[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .data_out(data_out[1])
`ifdef SM4_BLOCK_CNT_EN
        , .blk_cnt(blk_cnt[1])
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one block, wait for out_valid and compare against the queued expectation.
    task automatic do_block(input int sel, input logic [127:0] k, input logic [127:0] d,
                            input logic m, input logic [127:0] expv, input int lat, input bit toggle);
        int n;
        logic [127:0] e;
        key[sel] = k; data_in[sel] = d; mode[sel] = m; in_valid[sel] = 1'b1;
        check("in_ready_before_accept", 128'(in_ready[sel]), 128'd1);
        step();
        in_valid[sel] = 1'b0;
        exp_q.push_back(expv);
        n = 0;
        while (out_valid[sel] !== 1'b1 && n < 100) begin
            check("in_ready_busy", 128'(in_ready[sel]), 128'd0);
            if (toggle) begin
                key[sel]      = {$urandom, $urandom, $urandom, $urandom};
                data_in[sel]  = {$urandom, $urandom, $urandom, $urandom};
                mode[sel]     = ~mode[sel];
                in_valid[sel] = 1'b1;
            end
            step();
            n++;
        end
        in_valid[sel] = 1'b0;
        check("latency", 128'(n), 128'(lat));
        if (exp_q.size() == 0) begin
            check("queue_nonempty", 128'(exp_q.size()), 128'd1);
        end else begin
            e = exp_q.pop_front();
            $display("block sel=%0d mode=%0b data_out=%h expected=%h latency=%0d", sel, m, data_out[sel], e, n);
            check("data_out", data_out[sel], e);
        end
    endtask

    task automatic release_out(input int sel, input logic [127:0] held);
        out_ready[sel] = 1'b1;
        step();
        out_ready[sel] = 1'b0;
        check("in_ready_after_release", 128'(in_ready[sel]), 128'd1);
        check("out_valid_after_release", 128'(out_valid[sel]), 128'd0);
        check("data_out_held_idle", data_out[sel], held);
    endtask

    initial begin
        int accepts, outs, last_out;
        bit drop;
        logic [127:0] e;

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b0; mode[s] = 1'b0; key[s] = '0; data_in[s] = '0; out_ready[s] = 1'b0;
        end
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            check("reset_in_ready", 128'(in_ready[s]), 128'd1);
            check("reset_out_valid", 128'(out_valid[s]), 128'd0);
            check("reset_data_out", data_out[s], 128'd0);
        end
        rst = 1'b0;
        step();

        // Encrypt on R=1, then 20 cycles of backpressure.
        do_block(0, KEY_STD, KEY_STD, 1'b0, CT_STD, 32, 1'b0);
        for (int c = 0; c < 20; c++) begin
            step();
            check("bp_out_valid", 128'(out_valid[0]), 128'd1);
            check("bp_in_ready", 128'(in_ready[0]), 128'd0);
            check("bp_data_out", data_out[0], CT_STD);
        end
        release_out(0, CT_STD);

        // Decrypt on R=8.
        do_block(1, KEY_STD, CT_STD, 1'b1, KEY_STD, 4, 1'b0);
        release_out(1, KEY_STD);

        // Inputs churn during RUN; results must reflect the values captured at accept.
        do_block(1, KEY_STD, KEY_STD, 1'b0, CT_STD, 4, 1'b1);
        release_out(1, CT_STD);
        do_block(0, KEY_STD, CT_STD, 1'b1, KEY_STD, 32, 1'b1);
        release_out(0, KEY_STD);

        // Reset in the middle of RUN discards the block.
        key[0] = KEY_STD; data_in[0] = KEY_STD; mode[0] = 1'b0; in_valid[0] = 1'b1;
        step();
        in_valid[0] = 1'b0;
        for (int c = 0; c < 10; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrun_rst_out_valid", 128'(out_valid[0]), 128'd0);
        check("midrun_rst_data_out", data_out[0], 128'd0);
        check("midrun_rst_in_ready", 128'(in_ready[0]), 128'd1);
        do_block(0, KEY_STD, KEY_STD, 1'b0, CT_STD, 32, 1'b0);
        release_out(0, CT_STD);

        // Back-to-back blocks on R=8 with the sink always ready.
        rst = 1'b1;
        step();
        rst = 1'b0;
        key[1] = KEY_STD; data_in[1] = KEY_STD; mode[1] = 1'b0;
        in_valid[1] = 1'b1; out_ready[1] = 1'b1;
        accepts = 0; outs = 0; last_out = -1;
        for (int c = 0; c < 30; c++) begin
            drop = 1'b0;
            if (in_valid[1] && in_ready[1]) begin
                exp_q.push_back(CT_STD);
                accepts++;
                if (accepts == 3) drop = 1'b1;
            end
            if (out_valid[1] === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                $display("b2b cycle=%0d data_out=%h expected=%h", c, data_out[1], e);
                check("b2b_data_out", data_out[1], e);
                if (last_out >= 0) check("b2b_interval", 128'(c - last_out), 128'd6);
                last_out = c;
                outs++;
            end
            step();
            if (drop) in_valid[1] = 1'b0;
        end
        out_ready[1] = 1'b0;
        check("b2b_block_count", 128'(outs), 128'd3);
        check("queue_empty", 128'(exp_q.size()), 128'd0);

`ifdef SM4_BLOCK_CNT_EN
        check("blk_cnt_after_three", 128'(blk_cnt[1]), 128'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("blk_cnt_after_rst", 128'(blk_cnt[1]), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
